// File: rtl/spi_resp_pkg.sv
// spi_resp_pkg: shared definitions for the SPI register responder.
//   - responder FSM state encoding
//   - register file geometry (ADDR_W, NREGS)
//   - command byte field positions
//   - helper for the wrapping register pointer
package spi_resp_pkg;

  localparam int ADDR_W       = 5;
  localparam int NREGS        = 32;

  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_DIR_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Register pointer advance; the 5-bit sum wraps 31 -> 0 on its own.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + 5'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous input, with
// edge pulses derived from the synchronised level.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   din      : raw asynchronous input
//   level    : synchronised level (STAGES flops of latency)
//   rise     : one-clk pulse when the synchronised level goes 0 -> 1
//   fall     : one-clk pulse when the synchronised level goes 1 -> 0
// The chain resets to 0 so that a chip select held low across a reset does
// not look like a fresh select edge once reset is released.
module spi_sync_edge
  import spi_resp_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  // Synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= '0;
      prev_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
    end
  end

  assign level = chain_r[STAGES-1];
  assign rise  = chain_r[STAGES-1] & ~prev_r;
  assign fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 responder in front of a 32 x 8 register file.
// A frame is one command byte (addr in [7:3], write flag in [1]) followed by
// data bytes that auto-increment the register pointer with wrap-around.
// Ports:
//   Clk, Reset_h            : system clock, asynchronous active-high reset
//   SPI_SS_n/SCLK/MOSI      : SPI inputs, asynchronous to Clk
//   SPI_MISO, SPI_MISO_oe   : serial output and its enable (high while selected)
//   status_in, status_valid : byte returned during the command byte
//   loc_we/addr/wdata       : local fabric write port
//   loc_rdata               : combinational read of reg[loc_addr]
//   wr_strobe/addr/data     : one-clk notification of each completed SPI write
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] RESET_STATUS = 8'h00
) (
  input  logic              Clk,
  input  logic              Reset_h,
  input  logic              SPI_SS_n,
  input  logic              SPI_SCLK,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              SPI_MISO_oe,
  input  logic [7:0]        status_in,
  input  logic              status_valid,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic ss_level_s, ss_rise_s, ss_fall_s;
  logic sclk_rise_q_s, sclk_fall_q_s;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic mosi_s;

  state_e            state_r, state_nx_s;
  logic [2:0]        bitcnt_r, bitcnt_nx_s;
  logic [6:0]        rx_r, rx_nx_s;
  logic [7:0]        tx_r, tx_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s, addr_inc_s;
  logic              dir_r, dir_nx_s;
  logic              oe_r, oe_nx_s;
  logic              miso_r;
  logic              spi_we_s;
  logic [7:0]        byte_s;
  logic              wr_strobe_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic [7:0]        regs_r [NREGS];

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (Clk),
    .rst   (Reset_h),
    .din   (SPI_SCLK),
    .level (sclk_level_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk   (Clk),
    .rst   (Reset_h),
    .din   (SPI_SS_n),
    .level (ss_level_s),
    .rise  (ss_rise_s),
    .fall  (ss_fall_s)
  );

  // MOSI synchroniser; only the level is needed, sampled on SCLK rise.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      mosi_sync_r <= '0;
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPI_MOSI};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  // SCLK edges only count while selected; a fall must leave SCLK at idle low.
  assign sclk_rise_q_s = sclk_rise_s & ~ss_level_s;
  assign sclk_fall_q_s = sclk_fall_s & ~ss_level_s & ~sclk_level_s;

  // Byte completed by the current rise: seven bits already shifted plus MOSI.
  assign byte_s     = {rx_r, mosi_s};
  assign addr_inc_s = addr_next(addr_r);

  // Next-state and datapath decode for the framing FSM.
  always_comb begin
    state_nx_s  = state_r;
    bitcnt_nx_s = bitcnt_r;
    rx_nx_s     = rx_r;
    tx_nx_s     = tx_r;
    addr_nx_s   = addr_r;
    dir_nx_s    = dir_r;
    oe_nx_s     = oe_r;
    spi_we_s    = 1'b0;

    if (ss_fall_s) begin
      // A new select always restarts at the command byte.
      state_nx_s  = CMD;
      bitcnt_nx_s = 3'd0;
      rx_nx_s     = 7'd0;
      tx_nx_s     = status_valid ? status_in : RESET_STATUS;
      oe_nx_s     = 1'b1;
    end else if (ss_rise_s) begin
      // Deselect drops any partial byte.
      state_nx_s = IDLE;
      oe_nx_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = IDLE;
        end
        CMD, DATA: begin
          if (sclk_rise_q_s) begin
            rx_nx_s     = byte_s[6:0];
            bitcnt_nx_s = bitcnt_r + 3'd1;
            if (bitcnt_r == 3'd7) begin
              if (state_r == CMD) begin
                state_nx_s = DATA;
                addr_nx_s  = byte_s[CMD_ADDR_MSB:CMD_ADDR_LSB];
                dir_nx_s   = byte_s[CMD_DIR_BIT];
                if (byte_s[CMD_DIR_BIT]) begin
                  tx_nx_s = 8'h00;
                end else begin
                  tx_nx_s = regs_r[byte_s[CMD_ADDR_MSB:CMD_ADDR_LSB]];
                end
              end else if (dir_r) begin
                spi_we_s  = 1'b1;
                addr_nx_s = addr_inc_s;
                tx_nx_s   = 8'h00;
              end else begin
                addr_nx_s = addr_inc_s;
                tx_nx_s   = regs_r[addr_inc_s];
              end
            end else begin
              tx_nx_s = tx_r;
            end
          end else if (sclk_fall_q_s) begin
            // bitcnt == 0 means a byte was just loaded: keep its MSB on MISO.
            if (bitcnt_r != 3'd0) begin
              tx_nx_s = {tx_r[6:0], 1'b0};
            end else begin
              tx_nx_s = tx_r;
            end
          end else begin
            tx_nx_s = tx_r;
          end
        end
        default: begin
          state_nx_s = IDLE;
          oe_nx_s    = 1'b0;
        end
      endcase
    end
  end

  // Framing state, shift registers and registered SPI/notification outputs.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      state_r     <= IDLE;
      bitcnt_r    <= 3'd0;
      rx_r        <= 7'd0;
      tx_r        <= 8'h00;
      addr_r      <= 5'd0;
      dir_r       <= 1'b0;
      oe_r        <= 1'b0;
      miso_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 5'd0;
      wr_data_r   <= 8'h00;
    end else begin
      state_r     <= state_nx_s;
      bitcnt_r    <= bitcnt_nx_s;
      rx_r        <= rx_nx_s;
      tx_r        <= tx_nx_s;
      addr_r      <= addr_nx_s;
      dir_r       <= dir_nx_s;
      oe_r        <= oe_nx_s;
      // Driven from next-state values so MISO tracks tx[7] without extra lag.
      miso_r      <= oe_nx_s & tx_nx_s[7];
      wr_strobe_r <= spi_we_s;
      if (spi_we_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= byte_s;
      end
    end
  end

  // Register file; the SPI write is applied last so it wins an address clash.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      if (loc_we) begin
        regs_r[loc_addr] <= loc_wdata;
      end
      if (spi_we_s) begin
        regs_r[addr_r] <= byte_s;
      end
    end
  end

  assign SPI_MISO    = miso_r;
  assign SPI_MISO_oe = oe_r;
  assign wr_strobe   = wr_strobe_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign loc_rdata   = regs_r[loc_addr];

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: drives SPI frames with a 4-Clk-high / 4-Clk-low
// SCLK at a random sub-cycle phase, keeps a frame-level register model, and
// scoreboards MISO bytes and wr_strobe notifications.
module tb_spi_reg_responder;

  logic       Clk = 1'b0;
  logic       Reset_h = 1'b1;
  logic       SPI_SS_n = 1'b1;
  logic       SPI_SCLK = 1'b0;
  logic       SPI_MOSI = 1'b0;
  logic       SPI_MISO, SPI_MISO_oe;
  logic [7:0] status_in = 8'h00;
  logic       status_valid = 1'b0;
  logic       loc_we = 1'b0;
  logic [4:0] loc_addr = 5'd0;
  logic [7:0] loc_wdata = 8'h00;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  spi_reg_responder dut (
    .Clk(Clk), .Reset_h(Reset_h),
    .SPI_SS_n(SPI_SS_n), .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_MISO_oe(SPI_MISO_oe),
    .status_in(status_in), .status_valid(status_valid),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  model_regs [32];
  logic [7:0]  exp_miso_q [$];
  logic [7:0]  got_miso_q [$];
  logic [12:0] exp_wr_q [$];
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  int          phase = 3;
  int          coll_idx = -1;
  logic [4:0]  coll_addr = 5'd0;
  logic [7:0]  coll_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT or driver presents data.
  always @(negedge Clk) begin : monitor
    logic [12:0] e;
    logic [7:0]  g;
    if (wr_strobe === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_strobe_unexpected: got addr %0d data 0x%0h expected no strobe", wr_addr, wr_data);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[12:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
    while (got_miso_q.size() > 0) begin
      g = got_miso_q.pop_front();
      if (exp_miso_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL miso_unexpected: got 0x%0h expected nothing", g);
      end else begin
        check("miso_byte", 32'(g), 32'(exp_miso_q.pop_front()));
      end
    end
  end

  task automatic ss_low();
    @(posedge Clk);
    #(phase);
    SPI_SS_n = 1'b0;
  endtask

  task automatic ss_high();
    repeat (4) @(posedge Clk);
    #(phase);
    SPI_SS_n = 1'b1;
    repeat (6) @(posedge Clk);
  endtask

  // One SCLK period (4 Clk low, 4 Clk high); MISO sampled just before the rise.
  task automatic spi_bit(input logic b, input logic coll, input logic exp_oe, output logic m);
    SPI_MOSI = b;
    repeat (4) @(posedge Clk);
    #(phase);
    m = SPI_MISO;
    check("miso_oe", 32'(SPI_MISO_oe), 32'(exp_oe));
    SPI_SCLK = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    if (coll) begin
      loc_we    = 1'b1;
      loc_addr  = coll_addr;
      loc_wdata = coll_data;
    end
    @(posedge Clk);
    #1;
    loc_we = 1'b0;
    @(posedge Clk);
    #(phase);
    SPI_SCLK = 1'b0;
  endtask

  task automatic spi_frame(input int nbytes, input int extra_bits);
    logic m;
    ss_low();
    for (int i = 0; i < nbytes; i++) begin
      for (int k = 7; k >= 0; k--) begin
        spi_bit(tx_buf[i][k], (i == coll_idx) && (k == 0), 1'b1, m);
        rx_buf[i][k] = m;
      end
    end
    for (int k = 0; k < extra_bits; k++) begin
      spi_bit(tx_buf[nbytes][7-k], 1'b0, 1'b1, m);
    end
    ss_high();
  endtask

  // Reference model at frame level: tx_buf[0] is the command, then data bytes.
  task automatic do_frame(input int ndata, input int extra_bits);
    int a;
    int idx;
    logic wr;
    a  = int'(tx_buf[0][7:3]);
    wr = tx_buf[0][1];
    exp_miso_q.push_back(status_valid ? status_in : 8'h00);
    for (int i = 0; i < ndata; i++) begin
      idx = (a + i) % 32;
      if (wr) begin
        exp_miso_q.push_back(8'h00);
        model_regs[idx] = tx_buf[i+1];
        exp_wr_q.push_back({5'(idx), tx_buf[i+1]});
      end else begin
        exp_miso_q.push_back(model_regs[idx]);
      end
    end
    spi_frame(ndata + 1, extra_bits);
    for (int i = 0; i < ndata + 1; i++) begin
      got_miso_q.push_back(rx_buf[i]);
    end
  endtask

  task automatic local_write(input logic [4:0] a, input logic [7:0] d);
    @(posedge Clk);
    #1;
    loc_we = 1'b1;
    loc_addr = a;
    loc_wdata = d;
    @(posedge Clk);
    #1;
    loc_we = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic check_reg(input logic [4:0] a);
    @(negedge Clk);
    loc_addr = a;
    #1;
    check("loc_rdata", 32'(loc_rdata), 32'(model_regs[a]));
  endtask

  initial begin
    logic m;
    int nd;
    int ex;
    for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_miso_oe", 32'(SPI_MISO_oe), 32'd0);
    check("rst_miso", 32'(SPI_MISO), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    @(negedge Clk);
    Reset_h = 1'b0;
    check_reg(5'd0);
    check_reg(5'd31);

    // Single write: addr 5 <- C3, status not valid
    phase = 2;
    tx_buf[0] = 8'h2A;
    tx_buf[1] = 8'hC3;
    do_frame(1, 0);
    check_reg(5'd5);
    check("single_wr_reg5", 32'(loc_rdata), 32'h0000_00C3);

    // Burst read from 31 wrapping to 0
    local_write(5'd31, 8'h11);
    local_write(5'd0, 8'h22);
    status_valid = 1'b1;
    status_in = 8'h5A;
    phase = 7;
    tx_buf[0] = 8'hF8;
    tx_buf[1] = 8'($urandom);
    tx_buf[2] = 8'($urandom);
    do_frame(2, 0);
    check("burst_byte1", 32'(rx_buf[1]), 32'h0000_0011);
    check("burst_byte2", 32'(rx_buf[2]), 32'h0000_0022);

    // Aborted write: 5 data bits then deselect
    status_valid = 1'b0;
    tx_buf[0] = 8'h0A;
    tx_buf[1] = 8'hFF;
    do_frame(0, 5);
    check_reg(5'd1);
    tx_buf[0] = 8'h28;
    tx_buf[1] = 8'h00;
    do_frame(1, 0);
    check("after_abort_read5", 32'(rx_buf[1]), 32'h0000_00C3);

    // Collision: local 77 and SPI 99 to addr 3 on the same Clk
    phase = 5;
    tx_buf[0] = 8'h1A;
    tx_buf[1] = 8'h99;
    coll_idx = 1;
    coll_addr = 5'd3;
    coll_data = 8'h77;
    do_frame(1, 0);
    coll_idx = -1;
    check_reg(5'd3);
    check("collision_reg3", 32'(loc_rdata), 32'h0000_0099);

    // Reset mid-frame: remainder of the frame must be ignored
    phase = 4;
    tx_buf[0] = 8'h12;
    tx_buf[1] = 8'hAB;
    ss_low();
    for (int k = 7; k >= 5; k--) spi_bit(tx_buf[0][k], 1'b0, 1'b1, m);
    @(posedge Clk);
    #1;
    Reset_h = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst_oe", 32'(SPI_MISO_oe), 32'd0);
    check("midrst_miso", 32'(SPI_MISO), 32'd0);
    Reset_h = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
    for (int k = 4; k >= 0; k--) spi_bit(tx_buf[0][k], 1'b0, 1'b0, m);
    for (int k = 7; k >= 0; k--) spi_bit(tx_buf[1][k], 1'b0, 1'b0, m);
    ss_high();
    for (int i = 0; i < 32; i++) check_reg(5'(i));

    // Random frames against the model
    for (int f = 0; f < 350; f++) begin
      phase = $urandom_range(1, 9);
      status_valid = 1'($urandom);
      status_in = 8'($urandom);
      nd = $urandom_range(0, 2);
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 4; i++) tx_buf[i] = 8'($urandom);
      do_frame(nd, ex);
      if ($urandom_range(0, 3) == 0) local_write(5'($urandom), 8'($urandom));
      check_reg(tx_buf[0][7:3]);
      check_reg(5'($urandom));
    end

    repeat (10) @(posedge Clk);
    check("wr_queue_left", 32'(exp_wr_q.size()), 32'd0);
    check("miso_queue_left", 32'(exp_miso_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
